// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between the W stage (A) and the mul/div unit (B).
// Each port has a one-entry buffer; one buffered write commits per cycle into registered outputs.
module grf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aValid,
  output logic        aReady,
  input  logic [4:0]  aReg,
  input  logic [31:0] aData,
  input  logic [31:0] aPC,
  input  logic        bValid,
  output logic        bReady,
  input  logic [4:0]  bReg,
  input  logic [31:0] bData,
  input  logic [31:0] bPC,
  output logic        writeEnable,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] PCReg,
  output logic [31:0] pendingMask
);

  localparam int unsigned RegW  = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  typedef struct packed {
    logic             valid;
    logic [RegW-1:0]  dst;
    logic [DataW-1:0] data;
    logic [DataW-1:0] pc;
  } entryT;

  entryT           bufA;
  entryT           bufB;
  entryT           selEntry;
  logic            selA;
  logic            selB;
  logic            aOlder;
  logic            aLoad;
  logic            bLoad;
  logic            aHold;
  logic            bHold;
  logic            starved;
  logic [CntW-1:0] waitCnt;

  assign starved = (waitCnt == CntW'(MAX_WAIT));

  // Same-register pairs drain oldest first; otherwise A wins unless B has waited too long.
  always_comb begin
    selA = 1'b0;
    selB = 1'b0;
    if (bufA.valid && bufB.valid) begin
      if (bufA.dst == bufB.dst) begin
        selA = aOlder;
        selB = !aOlder;
      end else if (starved) begin
        selB = 1'b1;
      end else begin
        selA = 1'b1;
      end
    end else begin
      selA = bufA.valid;
      selB = bufB.valid;
    end
  end

  assign selEntry = selB ? bufB : bufA;
  assign aReady   = !bufA.valid || selA;
  assign bReady   = !bufB.valid || selB;
  assign aLoad    = aValid && aReady;
  assign bLoad    = bValid && bReady;
  assign aHold    = bufA.valid && !selA;
  assign bHold    = bufB.valid && !selB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufA <= '0;
    end else if (aLoad) begin
      bufA <= '{valid: 1'b1, dst: aReg, data: aData, pc: aPC};
    end else if (selA) begin
      bufA.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufB <= '0;
    end else if (bLoad) begin
      bufB <= '{valid: 1'b1, dst: bReg, data: bData, pc: bPC};
    end else if (selB) begin
      bufB.valid <= 1'b0;
    end
  end

  // Age: the entry that stays put while the other is loaded is the older one; a tie favours B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aOlder <= 1'b0;
    end else if (aHold && bLoad) begin
      aOlder <= 1'b1;
    end else if (bHold && aLoad) begin
      aOlder <= 1'b0;
    end else if (!(aHold && bHold)) begin
      aOlder <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (bHold) begin
      if (!starved) waitCnt <= waitCnt + CntW'(1);
    end else begin
      waitCnt <= '0;
    end
  end

  // Commit stage; writes to $0 drain but never raise writeEnable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
      PCReg       <= '0;
    end else if (selA || selB) begin
      writeEnable <= (selEntry.dst != '0);
      writeReg    <= selEntry.dst;
      writeData   <= selEntry.data;
      PCReg       <= selEntry.pc;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  always_comb begin
    pendingMask = '0;
    if (bufA.valid) pendingMask[bufA.dst] = 1'b1;
    if (bufB.valid) pendingMask[bufB.dst] = 1'b1;
    if (writeEnable) pendingMask[writeReg] = 1'b1;
    pendingMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter with MAX_WAIT = 3.
module tb_grf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        aValid;
  logic        aReady;
  logic [4:0]  aReg;
  logic [31:0] aData;
  logic [31:0] aPC;
  logic        bValid;
  logic        bReady;
  logic [4:0]  bReg;
  logic [31:0] bData;
  logic [31:0] bPC;
  logic        writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] PCReg;
  logic [31:0] pendingMask;

  int checks = 0;
  int errors = 0;

  grf_write_arbiter #(.MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .aValid(aValid), .aReady(aReady), .aReg(aReg), .aData(aData), .aPC(aPC),
    .bValid(bValid), .bReady(bReady), .bReg(bReg), .bData(bData), .bPC(bPC),
    .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData),
    .PCReg(PCReg), .pendingMask(pendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", writeEnable); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d expected 0", writeReg); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_data got %h expected 0", writeData); end
    checks++; if (PCReg !== 32'd0) begin errors++; $display("FAIL reset_pc got %h expected 0", PCReg); end
    checks++; if (pendingMask !== 32'd0) begin errors++; $display("FAIL reset_mask got %h expected 0", pendingMask); end
    checks++; if (aReady !== 1'b1 || bReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b expected 11", aReady, bReady); end
    step();
    step();
    checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL reset_held got we=%b mask=%h expected 0", writeEnable, pendingMask); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    aValid = 1'b1; aReg = 5'd10; aData = 32'd16; aPC = 32'h3000;
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL single_ready got %b expected 1", aReady); end
    step();
    aValid = 1'b0;
    checks++; if (pendingMask !== 32'h400) begin errors++; $display("FAIL single_mask_buf got %h expected 400", pendingMask); end
    checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL single_we_early got %b expected 0", writeEnable); end
    step();
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd10) begin errors++; $display("FAIL single_commit got we=%b reg=%0d expected we=1 reg=10", writeEnable, writeReg); end
    checks++; if (writeData !== 32'd16 || PCReg !== 32'h3000) begin errors++; $display("FAIL single_payload got data=%h pc=%h expected 10/3000", writeData, PCReg); end
    checks++; if (pendingMask !== 32'h400) begin errors++; $display("FAIL single_mask_out got %h expected 400", pendingMask); end
    step();
    checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL single_done got we=%b mask=%h expected 0", writeEnable, pendingMask); end
    checks++; if (writeReg !== 5'd10) begin errors++; $display("FAIL single_hold got %0d expected 10", writeReg); end
  endtask

  task automatic test_zero_drop();
    aValid = 1'b1; aReg = 5'd0; aData = 32'd3; aPC = 32'h44;
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL zero_ready got %b expected 1", aReady); end
    step();
    aValid = 1'b0;
    checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL zero_buf got we=%b mask=%h expected 0", writeEnable, pendingMask); end
    step();
    checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL zero_commit got we=%b mask=%h expected 0", writeEnable, pendingMask); end
    checks++; if (writeReg !== 5'd0 || writeData !== 32'd3 || PCReg !== 32'h44) begin errors++; $display("FAIL zero_drain got reg=%0d data=%h pc=%h expected 0/3/44", writeReg, writeData, PCReg); end
    step();
    checks++; if (writeEnable !== 1'b0 || aReady !== 1'b1) begin errors++; $display("FAIL zero_after got we=%b ready=%b expected 0/1", writeEnable, aReady); end
  endtask

  task automatic test_contention();
    aValid = 1'b1; aReg = 5'd1; aData = 32'd101; aPC = 32'h100;
    bValid = 1'b1; bReg = 5'd20; bData = 32'hB; bPC = 32'h200;
    checks++; if (aReady !== 1'b1 || bReady !== 1'b1) begin errors++; $display("FAIL cont_accept got %b%b expected 11", aReady, bReady); end
    step();
    bValid = 1'b0;
    aReg = 5'd2; aData = 32'd102;
    checks++; if (bReady !== 1'b0 || aReady !== 1'b1) begin errors++; $display("FAIL cont_ready0 got a=%b b=%b expected a=1 b=0", aReady, bReady); end
    checks++; if (pendingMask !== 32'h0010_0002) begin errors++; $display("FAIL cont_mask got %h expected 00100002", pendingMask); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (writeEnable !== 1'b1 || writeReg !== 5'(i)) begin errors++; $display("FAIL cont_a%0d got we=%b reg=%0d expected we=1 reg=%0d", i, writeEnable, writeReg, i); end
      aReg = 5'(i + 2); aData = 32'(100 + i + 2);
      if (i < 3) begin
        checks++; if (bReady !== 1'b0) begin errors++; $display("FAIL cont_bblock%0d got %b expected 0", i, bReady); end
      end else begin
        checks++; if (bReady !== 1'b1 || aReady !== 1'b0) begin errors++; $display("FAIL cont_guard got a=%b b=%b expected a=0 b=1", aReady, bReady); end
      end
    end
    step();
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd20 || writeData !== 32'hB) begin errors++; $display("FAIL cont_b got we=%b reg=%0d data=%h expected 1/20/b", writeEnable, writeReg, writeData); end
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL cont_aresume got %b expected 1", aReady); end
    step();
    aValid = 1'b0;
    checks++; if (writeReg !== 5'd4 || writeData !== 32'd104) begin errors++; $display("FAIL cont_a4 got reg=%0d data=%0d expected 4/104", writeReg, writeData); end
    step();
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd5) begin errors++; $display("FAIL cont_a5 got we=%b reg=%0d expected 1/5", writeEnable, writeReg); end
    step();
    checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL cont_idle got %b expected 0", writeEnable); end
  endtask

  task automatic test_same_reg();
    aValid = 1'b1; aReg = 5'd5; aData = 32'hA; aPC = 32'h500;
    bValid = 1'b1; bReg = 5'd5; bData = 32'hB; bPC = 32'h600;
    step();
    aValid = 1'b0; bValid = 1'b0;
    checks++; if (pendingMask !== 32'h20) begin errors++; $display("FAIL same_mask got %h expected 20", pendingMask); end
    checks++; if (aReady !== 1'b0 || bReady !== 1'b1) begin errors++; $display("FAIL same_order got a=%b b=%b expected a=0 b=1", aReady, bReady); end
    step();
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'hB) begin errors++; $display("FAIL same_first got we=%b reg=%0d data=%h expected 1/5/b", writeEnable, writeReg, writeData); end
    step();
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'hA) begin errors++; $display("FAIL same_second got we=%b reg=%0d data=%h expected 1/5/a", writeEnable, writeReg, writeData); end
    step();
    checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL same_idle got we=%b mask=%h expected 0", writeEnable, pendingMask); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      aValid = 1'b1; aReg = 5'(11 + i); aData = 32'(80 + i); aPC = 32'(16'h7000 + i);
      checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b expected 1", i, aReady); end
      step();
      if (writeEnable === 1'b1) pulses++;
      if (i > 0) begin
        checks++; if (writeEnable !== 1'b1 || writeReg !== 5'(10 + i)) begin errors++; $display("FAIL b2b_w%0d got we=%b reg=%0d expected 1/%0d", i, writeEnable, writeReg, 10 + i); end
      end
    end
    aValid = 1'b0;
    step();
    if (writeEnable === 1'b1) pulses++;
    checks++; if (writeReg !== 5'd18 || writeData !== 32'd87) begin errors++; $display("FAIL b2b_last got reg=%0d data=%0d expected 18/87", writeReg, writeData); end
    step();
    if (writeEnable === 1'b1) pulses++;
    checks++; if (pulses != 8) begin errors++; $display("FAIL b2b_pulses got %0d expected 8", pulses); end
  endtask

  task automatic test_reset_midflight();
    aValid = 1'b1; aReg = 5'd7; aData = 32'h77; aPC = 32'h900;
    bValid = 1'b1; bReg = 5'd8; bData = 32'h88; bPC = 32'h904;
    step();
    bValid = 1'b0;
    aReg = 5'd9; aData = 32'h99;
    step();
    aValid = 1'b0;
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd7) begin errors++; $display("FAIL mid_pre got we=%b reg=%0d expected 1/7", writeEnable, writeReg); end
    checks++; if (pendingMask !== 32'h380) begin errors++; $display("FAIL mid_mask got %h expected 380", pendingMask); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (writeEnable !== 1'b0 || writeReg !== 5'd0) begin errors++; $display("FAIL mid_async got we=%b reg=%0d expected 0/0", writeEnable, writeReg); end
    checks++; if (pendingMask !== 32'd0 || aReady !== 1'b1 || bReady !== 1'b1) begin errors++; $display("FAIL mid_clear got mask=%h rdy=%b%b expected 0/11", pendingMask, aReady, bReady); end
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (writeEnable !== 1'b0 || pendingMask !== 32'd0) begin errors++; $display("FAIL mid_post%0d got we=%b mask=%h expected 0", i, writeEnable, pendingMask); end
    end
  endtask

  initial begin
    reset = 1'b0;
    aValid = 1'b0; aReg = '0; aData = '0; aPC = '0;
    bValid = 1'b0; bReg = '0; bData = '0; bPC = '0;
    test_reset();
    test_single_write();
    test_zero_drop();
    test_contention();
    test_same_reg();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
